// File: rtl/vector_cache_pkg.sv
// vector_cache_pkg: shared mesh types for the vector-cache SRAM group.
// Direction ids, flit width constants and the round-robin pick helper.
package vector_cache_pkg;

    typedef enum logic [1:0] {
        WEST  = 2'b00,
        EAST  = 2'b01,
        SOUTH = 2'b10,
        NORTH = 2'b11
    } vc_dir_e;

    localparam int MESH_DIR_W   = 2;
    localparam int MESH_NUM_DIR = 4;
    localparam int MESH_RR_W    = 3;

    // Requester bits: [0] west, [1] north, [2] south.
    localparam logic [MESH_RR_W-1:0] RR_WEST = 3'b001;

    // First requester at or after the one-hot pointer, W->N->S order.
    function automatic logic [2:0] rr_pick(
        input logic [2:0] req,
        input logic [2:0] ptr
    );
        logic [2:0] g;
        g = '0;
        unique case (1'b1)
            ptr[0]: g = req[0] ? 3'b001 :
                        req[1] ? 3'b010 :
                        req[2] ? 3'b100 : 3'b000;
            ptr[1]: g = req[1] ? 3'b010 :
                        req[2] ? 3'b100 :
                        req[0] ? 3'b001 : 3'b000;
            ptr[2]: g = req[2] ? 3'b100 :
                        req[0] ? 3'b001 :
                        req[1] ? 3'b010 : 3'b000;
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/xy_mesh_fifo.sv
// xy_mesh_fifo: per-output-channel flit buffer with registered head.
// out_pld holds the last delivered flit while empty.
module xy_mesh_fifo #(
    parameter int PLD_W      = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [PLD_W-1:0] din,
    output logic             full,
    output logic             out_vld,
    output logic [PLD_W-1:0] out_pld,
    input  logic             out_rdy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

    logic [PLD_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    rd_nxt;
    logic [CW-1:0]    cnt_q;
    logic             pop;
    logic             do_push;

    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign out_vld = (cnt_q != '0);
    assign pop     = out_vld & out_rdy;
    assign do_push = push & ~full;
    assign rd_nxt  = (rd_q == LAST) ? '0 : rd_q + PW'(1);

    // Storage array, written on accepted push.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

    // Pointers, count and registered head flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            out_pld <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == LAST) ? '0 : wr_q + PW'(1);
            if (pop) rd_q <= rd_nxt;
            cnt_q <= cnt_q + CW'(do_push) - CW'(pop);
            if (pop) begin
                if (cnt_q > CW'(1)) out_pld <= mem[rd_nxt];
                else if (do_push) out_pld <= din;
            end else if (cnt_q == '0 && do_push) begin
                out_pld <= din;
            end
        end
    end

endmodule

// File: rtl/xy_mesh_router.sv
// xy_mesh_router: NUM_CH-channel XY crosspoint, buffered per output.
// Define XY_MESH_ROUTER_ERR_CHK_EN to drop/flag east-bound east_in flits.
module xy_mesh_router
    import vector_cache_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int PLD_W      = 128,
    parameter int DIR_LSB    = 0,
    parameter int FIFO_DEPTH = 2,
    parameter int DIAG       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       west_in_vld,
    input  logic [NUM_CH*PLD_W-1:0] west_in_pld,
    output logic [NUM_CH-1:0]       west_in_rdy,
    input  logic [NUM_CH-1:0]       east_in_vld,
    input  logic [NUM_CH*PLD_W-1:0] east_in_pld,
    output logic [NUM_CH-1:0]       east_in_rdy,
    input  logic [NUM_CH-1:0]       south_in_vld,
    input  logic [NUM_CH*PLD_W-1:0] south_in_pld,
    output logic [NUM_CH-1:0]       south_in_rdy,
    input  logic [NUM_CH-1:0]       north_in_vld,
    input  logic [NUM_CH*PLD_W-1:0] north_in_pld,
    output logic [NUM_CH-1:0]       north_in_rdy,
    output logic [NUM_CH-1:0]       west_out_vld,
    output logic [NUM_CH*PLD_W-1:0] west_out_pld,
    input  logic [NUM_CH-1:0]       west_out_rdy,
    output logic [NUM_CH-1:0]       east_out_vld,
    output logic [NUM_CH*PLD_W-1:0] east_out_pld,
    input  logic [NUM_CH-1:0]       east_out_rdy,
    output logic [NUM_CH-1:0]       south_out_vld,
    output logic [NUM_CH*PLD_W-1:0] south_out_pld,
    input  logic [NUM_CH-1:0]       south_out_rdy,
    output logic [NUM_CH-1:0]       north_out_vld,
    output logic [NUM_CH*PLD_W-1:0] north_out_pld,
    input  logic [NUM_CH-1:0]       north_out_rdy,
    output logic [NUM_CH-1:0]       err_dir
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [3:0]           i_vld, i_rdy;
        logic [3:0]           f_push, f_full;
        logic [3:0]           o_vld, o_rdy;
        logic [PLD_W-1:0]     i_pld [4];
        logic [PLD_W-1:0]     f_din [4];
        logic [PLD_W-1:0]     o_pld [4];
        logic [MESH_RR_W-1:0] rr_q, rr_d, req, gnt;
        vc_dir_e              tgt;
        logic                 drop;

        assign i_vld = {north_in_vld[c], south_in_vld[c],
                        east_in_vld[c], west_in_vld[c]};
        assign i_pld[WEST]  = west_in_pld[c*PLD_W +: PLD_W];
        assign i_pld[EAST]  = east_in_pld[c*PLD_W +: PLD_W];
        assign i_pld[SOUTH] = south_in_pld[c*PLD_W +: PLD_W];
        assign i_pld[NORTH] = north_in_pld[c*PLD_W +: PLD_W];
        assign o_rdy = {north_out_rdy[c], south_out_rdy[c],
                        east_out_rdy[c], west_out_rdy[c]};

        // Route inputs to output FIFOs; readies from registered state.
        always_comb begin
            f_push = '0;
            f_din  = '{default: '0};
            i_rdy  = '0;
            rr_d   = rr_q;
            req    = '0;
            gnt    = '0;
            drop   = 1'b0;
            tgt    = vc_dir_e'(i_pld[EAST][DIR_LSB +: MESH_DIR_W]);
            if (DIAG == 0) begin
                i_rdy[WEST]   = ~f_full[EAST];
                f_push[EAST]  = i_vld[WEST] & ~f_full[EAST];
                f_din[EAST]   = i_pld[WEST];
                i_rdy[EAST]   = ~f_full[WEST];
                f_push[WEST]  = i_vld[EAST] & ~f_full[WEST];
                f_din[WEST]   = i_pld[EAST];
                i_rdy[SOUTH]  = ~f_full[NORTH];
                f_push[NORTH] = i_vld[SOUTH] & ~f_full[NORTH];
                f_din[NORTH]  = i_pld[SOUTH];
                i_rdy[NORTH]  = ~f_full[SOUTH];
                f_push[SOUTH] = i_vld[NORTH] & ~f_full[SOUTH];
                f_din[SOUTH]  = i_pld[NORTH];
            end else begin
                req = {i_vld[SOUTH], i_vld[NORTH], i_vld[WEST]};
                if (!f_full[EAST]) gnt = rr_pick(req, rr_q);
                i_rdy[WEST]  = gnt[0];
                i_rdy[NORTH] = gnt[1];
                i_rdy[SOUTH] = gnt[2];
                f_push[EAST] = |gnt;
                if (gnt[1])      f_din[EAST] = i_pld[NORTH];
                else if (gnt[2]) f_din[EAST] = i_pld[SOUTH];
                else             f_din[EAST] = i_pld[WEST];
                if (|gnt) rr_d = {gnt[1], gnt[0], gnt[2]};
`ifdef XY_MESH_ROUTER_ERR_CHK_EN
                drop = (tgt == EAST);
`else
                if (tgt == EAST) tgt = WEST;
`endif
                if (drop) begin
                    i_rdy[EAST] = 1'b1;
                end else begin
                    i_rdy[EAST] = ~f_full[tgt];
                    f_push[tgt] = i_vld[EAST] & ~f_full[tgt];
                    f_din[tgt]  = i_pld[EAST];
                end
            end
        end

        // Round-robin pointer for the east merge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rr_q <= RR_WEST;
            else        rr_q <= rr_d;
        end

`ifdef XY_MESH_ROUTER_ERR_CHK_EN
        logic err_q;
        // Sticky flag for a dropped east-bound flit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                   err_q <= 1'b0;
            else if (i_vld[EAST] && drop) err_q <= 1'b1;
        end
        assign err_dir[c] = err_q;
`else
        assign err_dir[c] = 1'b0;
`endif

        for (genvar d = 0; d < 4; d++) begin : g_fifo
            xy_mesh_fifo #(
                .PLD_W      (PLD_W),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .push    (f_push[d]),
                .din     (f_din[d]),
                .full    (f_full[d]),
                .out_vld (o_vld[d]),
                .out_pld (o_pld[d]),
                .out_rdy (o_rdy[d])
            );
        end

        assign west_in_rdy[c]  = i_rdy[WEST];
        assign east_in_rdy[c]  = i_rdy[EAST];
        assign south_in_rdy[c] = i_rdy[SOUTH];
        assign north_in_rdy[c] = i_rdy[NORTH];

        assign west_out_vld[c]  = o_vld[WEST];
        assign east_out_vld[c]  = o_vld[EAST];
        assign south_out_vld[c] = o_vld[SOUTH];
        assign north_out_vld[c] = o_vld[NORTH];

        assign west_out_pld[c*PLD_W +: PLD_W]  = o_pld[WEST];
        assign east_out_pld[c*PLD_W +: PLD_W]  = o_pld[EAST];
        assign south_out_pld[c*PLD_W +: PLD_W] = o_pld[SOUTH];
        assign north_out_pld[c*PLD_W +: PLD_W] = o_pld[NORTH];
    end

endmodule

// File: tb/tb_xy_mesh_router.sv
// tb_xy_mesh_router: pass-through and diagonal tiles side by side,
// checked against queue-based reference model.
module tb_xy_mesh_router;

    localparam int CH = 8;
    localparam int W  = 128;
    localparam int D  = 2;

    typedef logic [W-1:0] flit_t;

    logic clk = 1'b0;
    logic rst_n;

    // [k] 0 = pass tile, 1 = diag tile; [d] 0 W, 1 E, 2 S, 3 N
    logic [CH-1:0]   ivld [2][4];
    logic [CH*W-1:0] ipld [2][4];
    logic [CH-1:0]   irdy [2][4];
    logic [CH-1:0]   ovld [2][4];
    logic [CH*W-1:0] opld [2][4];
    logic [CH-1:0]   ordy [2][4];
    logic [CH-1:0]   err  [2];

    int checks = 0;
    int errors = 0;

    flit_t    q [64][$];
    flit_t    last [64];
    int       rr [CH];
    int       gpos [CH];
    bit       drop_m [CH];
    logic [CH-1:0] err_m [2];
    logic [CH-1:0] e_rdy [2][4];
    int       tgt_m [2][4][CH];

    always #5 clk = ~clk;

    xy_mesh_router #(.DIAG(0)) u_pass (
        .clk(clk), .rst_n(rst_n),
        .west_in_vld(ivld[0][0]), .west_in_pld(ipld[0][0]),
        .west_in_rdy(irdy[0][0]),
        .east_in_vld(ivld[0][1]), .east_in_pld(ipld[0][1]),
        .east_in_rdy(irdy[0][1]),
        .south_in_vld(ivld[0][2]), .south_in_pld(ipld[0][2]),
        .south_in_rdy(irdy[0][2]),
        .north_in_vld(ivld[0][3]), .north_in_pld(ipld[0][3]),
        .north_in_rdy(irdy[0][3]),
        .west_out_vld(ovld[0][0]), .west_out_pld(opld[0][0]),
        .west_out_rdy(ordy[0][0]),
        .east_out_vld(ovld[0][1]), .east_out_pld(opld[0][1]),
        .east_out_rdy(ordy[0][1]),
        .south_out_vld(ovld[0][2]), .south_out_pld(opld[0][2]),
        .south_out_rdy(ordy[0][2]),
        .north_out_vld(ovld[0][3]), .north_out_pld(opld[0][3]),
        .north_out_rdy(ordy[0][3]),
        .err_dir(err[0])
    );

    xy_mesh_router #(.DIAG(1)) u_diag (
        .clk(clk), .rst_n(rst_n),
        .west_in_vld(ivld[1][0]), .west_in_pld(ipld[1][0]),
        .west_in_rdy(irdy[1][0]),
        .east_in_vld(ivld[1][1]), .east_in_pld(ipld[1][1]),
        .east_in_rdy(irdy[1][1]),
        .south_in_vld(ivld[1][2]), .south_in_pld(ipld[1][2]),
        .south_in_rdy(irdy[1][2]),
        .north_in_vld(ivld[1][3]), .north_in_pld(ipld[1][3]),
        .north_in_rdy(irdy[1][3]),
        .west_out_vld(ovld[1][0]), .west_out_pld(opld[1][0]),
        .west_out_rdy(ordy[1][0]),
        .east_out_vld(ovld[1][1]), .east_out_pld(opld[1][1]),
        .east_out_rdy(ordy[1][1]),
        .south_out_vld(ovld[1][2]), .south_out_pld(opld[1][2]),
        .south_out_rdy(ordy[1][2]),
        .north_out_vld(ovld[1][3]), .north_out_pld(opld[1][3]),
        .north_out_rdy(ordy[1][3]),
        .err_dir(err[1])
    );

    function automatic int qi(int k, int d, int c);
        return k * 32 + d * 8 + c;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++)
            for (int d = 0; d < 4; d++) begin
                ivld[k][d] = '0;
                ipld[k][d] = '0;
            end
    endtask

    task automatic set_ordy(input logic [CH-1:0] v);
        for (int k = 0; k < 2; k++)
            for (int d = 0; d < 4; d++) ordy[k][d] = v;
    endtask

    // Expected readies and destinations from current inputs/occupancy.
    task automatic model_eval();
        int ord [3];
        int g, t;
        logic [1:0] dir;
        ord = '{0, 3, 2};
        for (int k = 0; k < 2; k++)
            for (int d = 0; d < 4; d++) begin
                e_rdy[k][d] = '0;
                for (int c = 0; c < CH; c++) tgt_m[k][d][c] = -1;
            end
        for (int c = 0; c < CH; c++) begin
            for (int d = 0; d < 4; d++) begin
                t = d ^ 1;
                e_rdy[0][d][c] = q[qi(0, t, c)].size() < D;
                if (e_rdy[0][d][c] && ivld[0][d][c]) tgt_m[0][d][c] = t;
            end
            g = -1;
            gpos[c] = -1;
            if (q[qi(1, 1, c)].size() < D)
                for (int i = 0; i < 3; i++)
                    if (g < 0 && ivld[1][ord[(rr[c] + i) % 3]][c]) begin
                        g = ord[(rr[c] + i) % 3];
                        gpos[c] = (rr[c] + i) % 3;
                    end
            if (g >= 0) begin
                e_rdy[1][g][c] = 1'b1;
                tgt_m[1][g][c] = 1;
            end
            dir = ipld[1][1][c*W +: 2];
            drop_m[c] = 1'b0;
`ifdef XY_MESH_ROUTER_ERR_CHK_EN
            if (dir == 2'b01) begin
                e_rdy[1][1][c] = 1'b1;
                drop_m[c] = ivld[1][1][c];
            end else begin
`else
            begin
                if (dir == 2'b01) dir = 2'b00;
`endif
                t = int'(dir);
                e_rdy[1][1][c] = q[qi(1, t, c)].size() < D;
                if (e_rdy[1][1][c] && ivld[1][1][c]) tgt_m[1][1][c] = t;
            end
        end
    endtask

    // Apply one clock edge to the model.
    task automatic model_commit();
        for (int k = 0; k < 2; k++)
            for (int d = 0; d < 4; d++)
                for (int c = 0; c < CH; c++)
                    if (q[qi(k, d, c)].size() > 0 && ordy[k][d][c])
                        last[qi(k, d, c)] = q[qi(k, d, c)].pop_front();
        for (int k = 0; k < 2; k++)
            for (int d = 0; d < 4; d++)
                for (int c = 0; c < CH; c++)
                    if (tgt_m[k][d][c] >= 0)
                        q[qi(k, tgt_m[k][d][c], c)].push_back(
                            ipld[k][d][c*W +: W]);
        for (int c = 0; c < CH; c++) begin
            if (gpos[c] >= 0) rr[c] = (gpos[c] + 1) % 3;
            if (drop_m[c]) err_m[1][c] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [CH-1:0] ev;
        flit_t ep;
        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("k%0d d%0d in_rdy", k, d),
                    W'(irdy[k][d]), W'(e_rdy[k][d]));
                for (int c = 0; c < CH; c++)
                    ev[c] = q[qi(k, d, c)].size() > 0;
                chk($sformatf("k%0d d%0d out_vld", k, d),
                    W'(ovld[k][d]), W'(ev));
                for (int c = 0; c < CH; c++) begin
                    ep = ev[c] ? q[qi(k, d, c)][0] : last[qi(k, d, c)];
                    chk($sformatf("k%0d d%0d c%0d out_pld", k, d, c),
                        opld[k][d][c*W +: W], ep);
                end
            end
            chk($sformatf("k%0d err_dir", k), W'(err[k]), W'(err_m[k]));
        end
    endtask

    task automatic step();
        #1;
        model_eval();
        check_all();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("rst k%0d d%0d vld", k, d),
                    W'(ovld[k][d]), '0);
                for (int c = 0; c < CH; c++)
                    chk($sformatf("rst k%0d d%0d c%0d pld", k, d, c),
                        opld[k][d][c*W +: W], '0);
            end
            chk($sformatf("rst k%0d err", k), W'(err[k]), '0);
        end
        for (int i = 0; i < 64; i++) begin
            q[i].delete();
            last[i] = '0;
        end
        for (int c = 0; c < CH; c++) rr[c] = 0;
        err_m[0] = '0;
        err_m[1] = '0;
    endtask

    initial begin
        clear_inputs();
        set_ordy('1);
        do_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        // Pass tile: west ch3 -> east ch3 one cycle later.
        ipld[0][0][3*W +: W] = W'(8'hA5);
        ivld[0][0] = 8'h08;
        step();
        ivld[0][0] = '0;
        #1;
        chk("pass east vld", W'(ovld[0][1]), W'(8'h08));
        chk("pass east pld", opld[0][1][3*W +: W], W'(8'hA5));
        chk("pass west vld", W'(ovld[0][0]), '0);
        chk("pass north vld", W'(ovld[0][3]), '0);
        step();

        // Diag tile: three-way contention on ch0, grants W,N,S,...
        ivld[1][0] = 8'h01;
        ivld[1][2] = 8'h01;
        ivld[1][3] = 8'h01;
        for (int i = 0; i < 6; i++) begin
            ipld[1][0][W-1:0] = W'(32'h100 + i);
            ipld[1][3][W-1:0] = W'(32'h200 + i);
            ipld[1][2][W-1:0] = W'(32'h300 + i);
            #1;
            chk($sformatf("rr grant %0d", i),
                W'({irdy[1][2][0], irdy[1][3][0], irdy[1][0][0]}),
                W'(3'b001 << (i % 3)));
            step();
        end
        clear_inputs();
        step();

        // Diag tile: east_in ch5 steered by direction id.
        for (int i = 0; i < 3; i++) begin
            ipld[1][1][5*W +: W] =
                {W'(64'hBEEF_0000 + i), (i == 0) ? 2'b00 :
                                        (i == 1) ? 2'b10 : 2'b11};
            ivld[1][1] = 8'h20;
            step();
            #1;
            chk($sformatf("steer %0d", i),
                W'({ovld[1][3][5], ovld[1][2][5], ovld[1][0][5]}),
                W'(3'b001 << i));
        end
        clear_inputs();
        step();

        // Pass tile: fill east FIFO ch0 with downstream stalled.
        ordy[0][1] = '0;
        ivld[0][0] = 8'h01;
        for (int i = 0; i < 6; i++) begin
            ipld[0][0][W-1:0] = W'(32'h4000 + i);
            if (i == 4) ordy[0][1] = '1;
            #1;
            chk($sformatf("full rdy %0d", i), W'(irdy[0][0][0]),
                W'((i < 2 || i == 5) ? 1'b1 : 1'b0));
            step();
        end
        clear_inputs();
        repeat (3) step();

        // Diag tile: east_in ch1 with east direction id.
        ipld[1][1][1*W +: W] = W'(64'h1234_0001);
        ivld[1][1] = 8'h02;
        step();
        clear_inputs();
        #1;
`ifdef XY_MESH_ROUTER_ERR_CHK_EN
        chk("err drop vld", W'(ovld[1][0][1]), W'(1'b0));
        chk("err flag", W'(err[1]), W'(8'h02));
`else
        chk("err west vld", W'(ovld[1][0][1]), W'(1'b1));
        chk("err flag", W'(err[1]), '0);
`endif
        repeat (3) step();
        chk("err sticky", W'(err[1]), W'(err_m[1]));

        // Buffer flits, move RR off west, then reset mid-cycle.
        set_ordy('0);
        ivld[0][0] = 8'h04;
        ipld[0][0][2*W +: W] = W'(32'h5555);
        ivld[1][0] = 8'h01;
        step();
        ivld[1][0] = '0;
        step();
        clear_inputs();
        #2;
        do_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_ordy('1);
        ivld[1][0] = 8'h01;
        ivld[1][2] = 8'h01;
        ivld[1][3] = 8'h01;
        #1;
        chk("rst rr west", W'({irdy[1][2][0], irdy[1][3][0],
                              irdy[1][0][0]}), W'(3'b001));
        step();
        clear_inputs();
        step();

        // Random traffic on both tiles.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++)
                for (int d = 0; d < 4; d++) begin
                    ivld[k][d] = CH'($urandom);
                    ordy[k][d] = CH'($urandom | $urandom);
                    for (int c = 0; c < CH; c++)
                        ipld[k][d][c*W +: W] =
                            {$urandom, $urandom, $urandom, $urandom};
                end
            step();
        end
        clear_inputs();
        set_ordy('1);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/xy_mesh_router.md
# xy_mesh_router

Parametrised mesh crosspoint for the vector-cache SRAM group. It generalises the fixed 8-channel, no-backpressure XY switch to NUM_CH channels with valid/ready handshakes and per-output buffering. The diagonal east merge uses round-robin arbitration, and diagonal east-input traffic is steered by direction id. One instance carries one traffic class (read cmd, write cmd or data); the sram_group top instantiates one per class and per tile.

## Interface
- NUM_CH, 8, independent channels per direction
- PLD_W, 128, payload width per channel
- DIR_LSB, 0, bit offset of the 2-bit direction id in the payload (00 west, 01 east, 10 south, 11 north)
- FIFO_DEPTH, 2, entries per output channel FIFO (≥1)
- DIAG, 0, 1 = diagonal tile (merge/steer mode), 0 = pass-through tile
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- {west,east,south,north}_in_vld  in  NUM_CH  per-channel input valid
- {west,east,south,north}_in_pld  in  NUM_CH*PLD_W  input payload, channel c at [c*PLD_W +: PLD_W]
- {west,east,south,north}_in_rdy  out  NUM_CH  per-channel input ready
- {west,east,south,north}_out_vld  out  NUM_CH  output valid
- {west,east,south,north}_out_pld  out  NUM_CH*PLD_W  output payload
- {west,east,south,north}_out_rdy  in  NUM_CH  downstream ready
- err_dir  out  NUM_CH  sticky illegal-direction flag per channel

## Operation
- Transfer on vld&rdy at each port. Channels are fully independent.
- DIAG=0: west_in→east_out, east_in→west_out, north_in→south_out, south_in→north_out. in_rdy = destination FIFO not full.
- DIAG=1, east_out: round-robin among west_in, north_in, south_in per channel. 3-bit one-hot pointer, reset to west, order west→north→south.
  - Grant only when the east FIFO is not full.
  - in_rdy is asserted only to the granted requester.
  - Pointer rotates to the requester after the grantee on each accepted push; unchanged otherwise.
- DIAG=1, east_in steering: the direction field routes to west_out, south_out or north_out. east_in_rdy = selected FIFO not full.
- DIAG=1: west_in, north_in and south_in have no other destination. No straight pass-through.
- Every output is fed from its own FIFO. out_vld = FIFO non-empty; pop on out_vld&out_rdy.
- in_rdy depends only on registered FIFO state. There is no combinational out_rdy→in_rdy path, so a pop from a full FIFO frees space the next cycle.
- Reset values: all out_vld 0, out_pld 0, FIFO pointers/counts 0, RR pointers = west, err_dir 0.
- Reset mid-operation flushes all buffered flits. No partial state survives.

## Timing
- Latency: accepted input at cycle N → out_vld at N+1 (FIFO output registered, no bypass).
- Throughput: one flit/cycle/channel/output when FIFO_DEPTH≥2 and the downstream is always ready.
- FIFO_DEPTH=1 is legal at one flit every 2 cycles.
- Full: in_rdy low while count==FIFO_DEPTH, including a cycle with a simultaneous pop.
- Empty: out_vld low. out_pld holds its last value (0 after reset).
- Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Pointer wrap at FIFO_DEPTH-1 → 0. Non-power-of-2 depths are supported.

## Configuration
- XY_MESH_ROUTER_ERR_CHK_EN defined:
  - An east_in flit with direction 01 (east) in a DIAG=1 tile is accepted (rdy=1) and dropped.
  - err_dir[c] sets and stays set until reset.
- Not defined:
  - Direction 01 is treated as west (routed to west_out).
  - err_dir is tied 0.

## Structure
- vector_cache_pkg: vc_dir_e enum (WEST=2'b00, EAST=2'b01, SOUTH=2'b10, NORTH=2'b11). This replaces the per-file direction macros.
- vector_cache_pkg: mesh_flit_t helper width constants.
- Sub-module xy_mesh_fifo: PLD_W and FIFO_DEPTH parameters, push/pop, full/empty, registered output. One instance per output channel, giving 4*NUM_CH instances.
- Round-robin arbiter stays inline: 3 requesters, per channel.

## Test plan
- DIAG=0, NUM_CH=8, west_in ch3 pld 0xA5 at cycle 10, all out_rdy=1 → east_out_vld[3]=1 with pld 0xA5 at cycle 11. No other output toggles.
- DIAG=1, west/north/south all valid on ch0 for 6 cycles, east_out_rdy=1 → grants W,N,S,W,N,S. Exactly one in_rdy high per cycle.
- DIAG=1, east_in ch5 flits with dir 00, 10, 11 → arrive at west_out, south_out, north_out respectively after 1 cycle each.
- FIFO_DEPTH=2, east_out_rdy=0, 3 west pushes → first 2 accepted, in_rdy low from cycle 2. Release rdy → in_rdy returns the cycle after the first pop.
- With XY_MESH_ROUTER_ERR_CHK_EN, DIAG=1, east_in ch1 dir 01 → flit dropped, err_dir=8'h02 sticky. Without the macro → flit exits west_out, err_dir=0.
- Reset asserted with 2 flits buffered → all out_vld 0 asynchronously. After deassert there are no stale flits and the RR pointer is back at west.
